hazard_scoreboard: RTL

//  Parametrised successor of the ID-stage RAW stall logic. Replaces fixed EXE/MEM/WB rd compares with
//  a per-register scoreboard of in-flight writes, so hazard checking scales to any pipeline depth.

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_sb_entry.sv | 63 ++++++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: operand-check selects, stall causes
// and the default register index width.
package hazard_scoreboard_pkg;

    localparam int SB_ALEN = 5;

    typedef enum logic [1:0] {
        CHK_NONE    = 2'd0,
        CHK_RS1     = 2'd1,
        CHK_RS2     = 2'd2,
        CHK_RS1_RS2 = 2'd3
    } check_regs_t;

    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_RAW      = 2'd1,
        SRC_FULL     = 2'd2,
        SRC_LATE_WAW = 2'd3
    } stall_src_t;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight write tracking: pending-write count
// plus a flag saying the youngest pending result is not yet bypassable.
module sb_entry #(
    parameter int MAX_PEND = 3,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_issue,
    input  logic i_issue_late,
    input  logic i_retire,
    input  logic i_late_done,
    input  logic i_flush,
    output logic o_pend,
    output logic o_full,
    output logic o_late,
    output logic o_err
);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PEND);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          late_q, late_d;
    logic          dec;

    always_comb begin
        cnt_d  = cnt_q;
        late_d = late_q;
        o_err  = 1'b0;
        dec    = i_retire && (cnt_q != '0);
        if (i_flush) begin
            cnt_d  = '0;
            late_d = 1'b0;
        end else begin
            // A simultaneous issue and retire leave the count where it was.
            case ({i_issue, dec})
                2'b10:   if (cnt_q != FULL_CNT) cnt_d = cnt_q + ONE_CNT;
                2'b01:   cnt_d = cnt_q - ONE_CNT;
                default: cnt_d = cnt_q;
            endcase
            if (i_issue)
                late_d = i_issue_late;
            else if (i_late_done || (dec && cnt_q == ONE_CNT))
                late_d = 1'b0;
            o_err = (i_retire && cnt_q == '0) || (i_late_done && !late_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            late_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            late_q <= late_d;
        end
    end

    assign o_pend = (cnt_q != '0);
    assign o_full = (cnt_q == FULL_CNT);
    assign o_late = late_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: per-register in-flight write tracking,
// stall/forward decisions for two source operands, and stall statistics.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int ALEN     = SB_ALEN,
    parameter int MAX_PEND = 3,
    parameter int FWD_EN   = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_is_valid,
    input  logic [ALEN-1:0] i_rs1,
    input  logic [ALEN-1:0] i_rs2,
    input  logic [1:0]      i_check_regs,
    input  logic            i_issue,
    input  logic            i_issue_wr,
    input  logic [ALEN-1:0] i_issue_rd,
    input  logic            i_issue_late,
    input  logic            i_late_done,
    input  logic [ALEN-1:0] i_late_rd,
    input  logic            i_retire,
    input  logic [ALEN-1:0] i_retire_rd,
    input  logic            i_flush,
    output logic            o_stall,
    output stall_src_t      o_stall_src,
    output logic            o_fwd_rs1,
    output logic            o_fwd_rs2,
    output logic [15:0]     o_stall_cnt,
    output logic            o_timeout,
    output logic            o_err
);
    localparam logic          FWD     = (FWD_EN != 0);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_CNT  = TW'(TIMEOUT);

    logic [NREGS-1:0] pend_v, full_v, late_v, err_v;

    // x0 is hardwired: never pending, never late, never an error source.
    assign pend_v[0] = 1'b0;
    assign full_v[0] = 1'b0;
    assign late_v[0] = 1'b0;
    assign err_v[0]  = 1'b0;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
        sb_entry #(.MAX_PEND(MAX_PEND)) u_entry (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_issue      (i_issue && i_issue_wr && (i_issue_rd == ALEN'(gi))),
            .i_issue_late (i_issue_late),
            .i_retire     (i_retire && (i_retire_rd == ALEN'(gi))),
            .i_late_done  (i_late_done && (i_late_rd == ALEN'(gi))),
            .i_flush      (i_flush),
            .o_pend       (pend_v[gi]),
            .o_full       (full_v[gi]),
            .o_late       (late_v[gi]),
            .o_err        (err_v[gi])
        );
    end

    logic chk1, chk2, active, raw1, raw2, full, lwaw, stall;

    always_comb begin
        active = i_is_valid && i_rst_n;
        chk1   = (i_check_regs == CHK_RS1 || i_check_regs == CHK_RS1_RS2) && (i_rs1 != '0);
        chk2   = (i_check_regs == CHK_RS2 || i_check_regs == CHK_RS1_RS2) && (i_rs2 != '0);
        raw1   = chk1 && pend_v[i_rs1] && (!FWD || late_v[i_rs1]);
        raw2   = chk2 && pend_v[i_rs2] && (!FWD || late_v[i_rs2]);
        full   = i_issue_wr && (i_issue_rd != '0) && full_v[i_issue_rd];
        lwaw   = i_issue_wr && i_issue_late && late_v[i_issue_rd];
        stall  = active && (raw1 || raw2 || full || lwaw);

        o_stall     = stall;
        o_fwd_rs1   = active && chk1 && pend_v[i_rs1] && FWD && !late_v[i_rs1];
        o_fwd_rs2   = active && chk2 && pend_v[i_rs2] && FWD && !late_v[i_rs2];
        o_stall_src = SRC_NONE;
        if (stall) begin
            if (raw1 || raw2)
                o_stall_src = SRC_RAW;
            else if (full)
                o_stall_src = SRC_FULL;
            else
                o_stall_src = SRC_LATE_WAW;
        end
    end

    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [TW-1:0] consec_q, consec_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        consec_d = '0;
        if (stall)
            consec_d = (consec_q == TO_CNT) ? consec_q : consec_q + TW'(1);
        timeout_d = timeout_q || (consec_d == TO_CNT);
        err_d     = err_q || (|err_v);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_timeout   = timeout_q;
    assign o_err       = err_q;

endmodule
